// File: rtl/mcu_pkg.sv
// Shared MCU definitions: datapath widths, PC stepping and the fetch queue entry layout.
package mcu_pkg;
  localparam int PC_W = 32;
  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0;
  localparam logic [PC_W-1:0] PC_STEP = 32'd4;
  localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 32'h0;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc_plus4;
  } fetch_entry_t;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock circular FIFO with push/pop/clear and a combinational head output.
// The caller only pushes when count < DEPTH or when it pops in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;

  // Clear discards everything by catching the read pointer up to the write pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= wr_ptr;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clear && !reset) mem[wr_ptr] <= din;
  end

  assign head = mem[rd_ptr];
endmodule

// File: rtl/inst_fetch_queue.sv
// Instruction prefetch stage: owns the fetch PC, buffers fetched words with PC+4,
// and hands them to decode; a decode redirect flushes the queue and restarts fetch.
module inst_fetch_queue
  import mcu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  output logic [31:0]   imem_addr,
  input  logic [31:0]   imem_rdata,
  input  logic          redirect_valid,
  input  logic [31:0]   redirect_pc,
  output logic          instr_valid,
  output logic [31:0]   instr,
  output logic [31:0]   pc_plus4,
  input  logic          instr_ready,
  output logic [CW-1:0] occupancy
);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [PC_W-1:0] fetch_pc;
  logic [PC_W-1:0] fetch_pc_next;
  logic            push;
  logic            pop;
  fetch_entry_t    wr_entry;
  fetch_entry_t    head_entry;
  logic [CW-1:0]   count;

  // Handshake: a head word transfers on any cycle where instr_valid && instr_ready,
  // unless redirect_valid is high, in which case the head is flushed instead.
  assign pop           = instr_valid & instr_ready & ~redirect_valid;
  assign push          = ~redirect_valid & ((count < FULL_COUNT) | pop);
  assign fetch_pc_next = fetch_pc + PC_STEP;
  assign wr_entry      = '{instr: imem_rdata, pc_plus4: fetch_pc_next};

  always_ff @(posedge clk) begin
    if (reset)               fetch_pc <= RESET_PC;
    else if (redirect_valid) fetch_pc <= redirect_pc;
    else if (push)           fetch_pc <= fetch_pc_next;
  end

  sync_fifo #(
    .WIDTH($bits(fetch_entry_t)),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clear (redirect_valid),
    .push  (push),
    .pop   (pop),
    .din   (wr_entry),
    .head  (head_entry),
    .count (count)
  );

  // Stale array contents never leave the block: outputs are zero while empty.
  assign imem_addr   = fetch_pc;
  assign instr_valid = (count != '0);
  assign instr       = instr_valid ? head_entry.instr : NOP_INSTR;
  assign pc_plus4    = instr_valid ? head_entry.pc_plus4 : '0;
  assign occupancy   = count;
endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue; the instruction memory returns (addr>>2)+100.
module tb_inst_fetch_queue;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] pc_plus4;
  logic        instr_ready = 1'b0;
  logic [2:0]  occupancy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign imem_rdata = (imem_addr >> 2) + 32'd100;

  inst_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .pc_plus4       (pc_plus4),
    .instr_ready    (instr_ready),
    .occupancy      (occupancy)
  );

  // Drives and samples happen on negedge; leaves the bench in the first cycle after release.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h expected %h", imem_addr, 32'h0); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", instr_valid); end
    checks++; if (instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h expected 0", instr); end
    checks++; if (pc_plus4 !== 32'h0) begin errors++; $display("FAIL reset_pc4: got %h expected 0", pc_plus4); end
    checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL reset_occ: got %0d expected 0", occupancy); end
  endtask

  task automatic test_free_run();
    instr_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL free_valid[%0d]: got %b expected 1", i, instr_valid); end
      checks++; if (instr !== 32'(100 + i)) begin errors++; $display("FAIL free_instr[%0d]: got %0d expected %0d", i, instr, 100 + i); end
      checks++; if (pc_plus4 !== 32'(4 * (i + 1))) begin errors++; $display("FAIL free_pc4[%0d]: got %0d expected %0d", i, pc_plus4, 4 * (i + 1)); end
      checks++; if (occupancy !== 3'd1) begin errors++; $display("FAIL free_occ[%0d]: got %0d expected 1", i, occupancy); end
    end
  endtask

  task automatic test_stall_and_full_stream();
    do_reset();
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      checks++;
      if (occupancy !== 3'((c < 4) ? c : 4)) begin
        errors++; $display("FAIL stall_occ[%0d]: got %0d expected %0d", c, occupancy, (c < 4) ? c : 4);
      end
    end
    checks++; if (imem_addr !== 32'd16) begin errors++; $display("FAIL stall_addr: got %0d expected 16", imem_addr); end
    checks++; if (instr !== 32'd100) begin errors++; $display("FAIL stall_head: got %0d expected 100", instr); end
    instr_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL full_valid[%0d]: got %b expected 1", i, instr_valid); end
      checks++; if (instr !== 32'(100 + i)) begin errors++; $display("FAIL full_instr[%0d]: got %0d expected %0d", i, instr, 100 + i); end
      checks++; if (pc_plus4 !== 32'(4 * (i + 1))) begin errors++; $display("FAIL full_pc4[%0d]: got %0d expected %0d", i, pc_plus4, 4 * (i + 1)); end
      checks++; if (occupancy !== 3'd4) begin errors++; $display("FAIL full_occ[%0d]: got %0d expected 4", i, occupancy); end
    end
  endtask

  task automatic test_redirect();
    do_reset();
    repeat (3) @(negedge clk);
    checks++; if (occupancy !== 3'd3) begin errors++; $display("FAIL redir_pre_occ: got %0d expected 3", occupancy); end
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    @(negedge clk);
    redirect_valid = 1'b0;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL redir_valid: got %b expected 0", instr_valid); end
    checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL redir_occ: got %0d expected 0", occupancy); end
    checks++; if (imem_addr !== 32'h40) begin errors++; $display("FAIL redir_addr: got %h expected 40", imem_addr); end
    checks++; if (instr !== 32'h0) begin errors++; $display("FAIL redir_instr0: got %h expected 0", instr); end
    @(negedge clk);
    checks++; if (instr !== 32'd116) begin errors++; $display("FAIL redir_target: got %0d expected 116", instr); end
    checks++; if (pc_plus4 !== 32'h44) begin errors++; $display("FAIL redir_pc4: got %h expected 44", pc_plus4); end
    checks++; if (occupancy !== 3'd1) begin errors++; $display("FAIL redir_occ1: got %0d expected 1", occupancy); end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    @(negedge clk);
    redirect_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (occupancy !== 3'd2) begin errors++; $display("FAIL mid_pre_occ: got %0d expected 2", occupancy); end
    reset = 1'b1;
    @(negedge clk);
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b expected 0", instr_valid); end
    checks++; if (instr !== 32'h0) begin errors++; $display("FAIL mid_instr: got %h expected 0", instr); end
    checks++; if (pc_plus4 !== 32'h0) begin errors++; $display("FAIL mid_pc4: got %h expected 0", pc_plus4); end
    checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL mid_occ: got %0d expected 0", occupancy); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL mid_addr: got %h expected 0", imem_addr); end
    reset = 1'b0;
    @(negedge clk);
    checks++; if (instr !== 32'd100) begin errors++; $display("FAIL mid_after_instr: got %0d expected 100", instr); end
    checks++; if (pc_plus4 !== 32'd4) begin errors++; $display("FAIL mid_after_pc4: got %0d expected 4", pc_plus4); end
  endtask

  task automatic test_pc_wrap();
    do_reset();
    instr_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    @(negedge clk);
    redirect_valid = 1'b0;
    checks++; if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_addr0: got %h expected fffffffc", imem_addr); end
    @(negedge clk);
    checks++; if (instr !== 32'h4000_0063) begin errors++; $display("FAIL wrap_instr: got %h expected 40000063", instr); end
    checks++; if (pc_plus4 !== 32'h0) begin errors++; $display("FAIL wrap_pc4: got %h expected 0", pc_plus4); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_addr1: got %h expected 0", imem_addr); end
    @(negedge clk);
    checks++; if (instr !== 32'd100) begin errors++; $display("FAIL wrap_next_instr: got %0d expected 100", instr); end
    checks++; if (pc_plus4 !== 32'd4) begin errors++; $display("FAIL wrap_next_pc4: got %0d expected 4", pc_plus4); end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_stall_and_full_stream();
    test_redirect();
    test_reset_midstream();
    test_pc_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/inst_fetch_queue.md
# inst_fetch_queue

Instruction prefetch stage between `inst_mem` and the decode pipeline register of the five-stage MCU. Owns the fetch PC, drives the instruction memory address, and buffers up to DEPTH fetched words with their PC+4. Decode pulls from the queue head under a valid/ready handshake, and a branch or jump redirect from decode flushes the queue and restarts fetch. Decouples decode stalls from fetch, so fetch keeps running while decode is held.

## Interface
- DEPTH, 4: queue entries; power of two, ≥2
- RESET_PC, 32'h0: fetch PC after reset
- clk  in  1  single clock; all state updates on posedge
- reset  in  1  synchronous, active-high; one clk edge with reset=1 fully initialises the block
- imem_addr  out  32  fetch PC to `inst_mem.A`; combinational read
- imem_rdata  in  32  `inst_mem.RD` for imem_addr, valid in the same cycle
- redirect_valid  in  1  taken branch or jump resolved in decode (PCSrcD != 0)
- redirect_pc  in  32  target (PCBranchD or PCJumpD)
- instr_valid  out  1  queue head holds an instruction
- instr  out  32  head instruction; 32'h0 (NOP) when !instr_valid
- pc_plus4  out  32  head PC+4; 32'h0 when !instr_valid
- instr_ready  in  1  decode accepts head this cycle (= !StallD)
- occupancy  out  $clog2(DEPTH)+1  current entry count, for debug and bench

## Operation
- State: fetch_pc (32), entry array {instr, pc_plus4} × DEPTH, rd_ptr and wr_ptr ($clog2(DEPTH) bits, natural wrap), count.
- imem_addr = fetch_pc at all times.
- pop = instr_valid & instr_ready & !redirect_valid.
- push = !redirect_valid & (count < DEPTH | pop). Push is also allowed when the queue is full and a pop happens in the same cycle.
- On push: entry[wr_ptr] <= {imem_rdata, fetch_pc+4}; wr_ptr++; fetch_pc <= fetch_pc+4.
- On pop: rd_ptr++. count changes by push-pop: +1, 0 or −1.
- Redirect has highest priority after reset:
  - rd_ptr <= wr_ptr and count <= 0.
  - fetch_pc <= redirect_pc.
  - No push that cycle.
  - The branch at the head counts as consumed by decode whether or not instr_ready is high. No delay slot, which matches CLRD semantics.
- PC arithmetic is modulo 2^32. fetch_pc+4 wraps silently from 32'hFFFFFFFC to 0.
- redirect_pc[1:0] is not checked. Alignment is the compiler's responsibility.
- Outputs instr and pc_plus4 are driven from entry[rd_ptr], gated to 0 when count == 0.
- Reset (synchronous, also mid-operation):
  - fetch_pc <= RESET_PC; pointers and count <= 0.
  - instr_valid = 0; instr = 0; pc_plus4 = 0; occupancy = 0.
  - Entry array contents are don't-care.

## Timing
- Fetch-to-head latency is 1 cycle. A word fetched in cycle n is visible at the head in cycle n+1 if the queue was empty.
- First cycle after reset release: imem_addr = RESET_PC, instr_valid = 0.
- Next cycle: instr_valid = 1, instr = mem[RESET_PC], pc_plus4 = RESET_PC+4.
- Redirect asserted in cycle n:
  - Cycle n+1: instr_valid = 0, imem_addr = redirect_pc.
  - Cycle n+2: target instruction at the head.
  - Branch penalty is 1 bubble, equal to the existing pipeline.
- Sustained throughput is 1 instruction/cycle with instr_ready held high, including when full.
- With instr_ready low, fetch continues until count == DEPTH and then holds fetch_pc.

## Structure
- Shared `mcu_pkg`: PC_W = 32, INSTR_W = 32, NOP_INSTR = 32'h0, PC_STEP = 4, RESET_PC default.
- One sub-module, `sync_fifo` (parameterised WIDTH/DEPTH, push/pop/clear, count, head output). Reusable for a later store buffer.
- The top handles fetch_pc, push/pop/redirect priority and output gating.

## Test plan
- Reset then free run, instr_ready = 1, mem[k] = k+100 -> head sequence 100, 101, 102…; pc_plus4 = 4, 8, 12…; occupancy stays 1.
- instr_ready = 0 for 10 cycles, DEPTH = 4 -> occupancy saturates at 4; imem_addr holds 16. On release, 4 buffered words drain in order without gaps.
- Full queue with instr_ready = 1 -> push and pop in the same cycle; occupancy stays 4; no word lost or duplicated.
- Redirect_valid with redirect_pc = 32'h40 while occupancy = 3 and instr_ready = 0 -> next cycle instr_valid = 0, occupancy = 0, imem_addr = 32'h40. Following cycle: instr = mem[16], pc_plus4 = 32'h44.
- Reset asserted mid-stream with occupancy = 2 -> after one edge, all outputs 0 and imem_addr = RESET_PC. Old entries are never presented.
- fetch_pc = 32'hFFFFFFFC -> pushed pc_plus4 = 0 and next imem_addr = 0.
